// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and constants for the multdiv issue sequencer.
package md_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  typedef enum logic {
    MD_OP_MULT = 1'b0,
    MD_OP_DIV  = 1'b1
  } md_op_e;

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bundle of issue, multdiv and writeback signals around the issue sequencer.
// The master side is the sequencer itself; the slave side is the X stage,
// the multdiv unit and the M/W consumer.
interface multdiv_issue_ctrl_if import md_pkg::*; ();

  logic              issue_valid;
  logic              issue_is_div;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [RD_W-1:0]   issue_rd;

  logic              stall;
  logic [DATA_W-1:0] md_operandA;
  logic [DATA_W-1:0] md_operandB;
  logic              md_ctrl_Mult;
  logic              md_ctrl_Div;
  logic [DATA_W-1:0] md_result;
  logic              md_except;
  logic              md_ready;

  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_except;
  logic              wb_timeout;
  logic              busy;

  modport master (
    input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd,
    input  md_result, md_except, md_ready,
    output stall, md_operandA, md_operandB, md_ctrl_Mult, md_ctrl_Div,
    output wb_valid, wb_rd, wb_data, wb_except, wb_timeout, busy
  );

  modport slave (
    output issue_valid, issue_is_div, issue_a, issue_b, issue_rd,
    output md_result, md_except, md_ready,
    input  stall, md_operandA, md_operandB, md_ctrl_Mult, md_ctrl_Div,
    input  wb_valid, wb_rd, wb_data, wb_except, wb_timeout, busy
  );

endinterface

// File: rtl/multdiv_issue_ctrl_watchdog.sv
// Wait-cycle watchdog: cleared when an op starts, counts while waiting,
// and flags the last allowed wait cycle.
module md_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  // Count wait cycles; a fresh op always starts from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue sequencer for the multi-cycle multdiv unit: latches one request,
// pulses the start strobe once, stalls the front end until multdiv finishes
// or the watchdog gives up, then presents a one-cycle writeback.
module multdiv_issue_ctrl import md_pkg::*; #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  multdiv_issue_ctrl_if.master bus
);

  md_state_e         state_q;
  md_state_e         state_d;
  md_op_e            op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic              wb_except_q;
  logic              wb_timeout_q;
  logic              wd_tc;

  md_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q == MD_START),
    .enable (state_q == MD_WAIT),
    .tc     (wd_tc)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus strobes; ready only matters while waiting, and DONE
  // always returns to IDLE so the retiring instruction cannot re-issue.
  always_comb begin
    state_d          = state_q;
    bus.stall        = 1'b0;
    bus.md_ctrl_Mult = 1'b0;
    bus.md_ctrl_Div  = 1'b0;
    bus.wb_valid     = 1'b0;
    case (state_q)
      MD_IDLE: begin
        bus.stall = bus.issue_valid;
        if (bus.issue_valid) state_d = MD_START;
      end
      MD_START: begin
        bus.stall        = 1'b1;
        bus.md_ctrl_Div  = (op_q == MD_OP_DIV);
        bus.md_ctrl_Mult = (op_q == MD_OP_MULT);
        state_d          = MD_WAIT;
      end
      MD_WAIT: begin
        bus.stall = 1'b1;
        if (bus.md_ready || wd_tc) state_d = MD_DONE;
      end
      MD_DONE: begin
        bus.wb_valid = 1'b1;
        state_d      = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Operand and tag latches, loaded only when a new op is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q <= MD_OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
    end else if (state_q == MD_IDLE && bus.issue_valid) begin
      op_q <= bus.issue_is_div ? MD_OP_DIV : MD_OP_MULT;
      a_q  <= bus.issue_a;
      b_q  <= bus.issue_b;
      rd_q <= bus.issue_rd;
    end
  end

  // Writeback capture on completion; a real result beats a coinciding timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_except_q  <= 1'b0;
      wb_timeout_q <= 1'b0;
    end else if (state_q == MD_WAIT) begin
      if (bus.md_ready) begin
        wb_data_q    <= bus.md_result;
        wb_rd_q      <= rd_q;
        wb_except_q  <= bus.md_except;
        wb_timeout_q <= 1'b0;
      end else if (wd_tc) begin
        wb_data_q    <= '0;
        wb_rd_q      <= rd_q;
        wb_except_q  <= 1'b1;
        wb_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.md_operandA = a_q;
  assign bus.md_operandB = b_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_except   = wb_except_q;
  assign bus.wb_timeout  = wb_timeout_q;
  assign bus.busy        = (state_q != MD_IDLE);

endmodule
